decoder_sweep_ctrl: RTL and testbench
=====================================

DECODER_SWEEP_CTRL -- requirements
Module: decoder_sweep_ctrl

Interface
REQ-001 Parameter DWELL, default 2: cycles each input code is held on the decoder; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  single-cycle sweep request; sampled only in IDLE.
REQ-005 mode  input  2  sweep size, latched on accepted start:
- 00 = 2:4 decoder
- 01 = 3:8 decoder
- 10 = 4:16 decoder
- 11 = disabled
REQ-006 Z  output  2  registered decoder select, drives decoder Z.
REQ-007 X  output  4  registered decoder code, drives decoder X.
REQ-008 Y  input  16  decoder one-hot result (combinational from Z/X).
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 err  output  1  sticky: at least one mismatch in the last sweep.
REQ-012 fail_x  output  4  X value of the first mismatch in the last sweep.
REQ-013 fail_cnt  output  5  mismatch count for the last sweep, saturating at 31.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE and FINISH.
REQ-015 IDLE: start=1 SHALL be accepted and move to DRIVE on the next edge, with:
- Z=mode, X=0, busy=1
- dwell counter cleared
- err, fail_x, fail_cnt cleared
REQ-016 start SHALL be ignored in DRIVE and FINISH; no restart and no relatch of mode.
REQ-017 Last code SHALL be 3 for mode 00, 7 for mode 01, 15 for mode 10, and 0 for mode 11 (single step).
REQ-018 Expected Y SHALL be one-hot with bit X set for modes 00/01/10, and 16'h0000 for mode 11.
REQ-019 DRIVE: each code SHALL be held exactly DWELL cycles, with the dwell counter counting 0..DWELL-1.
REQ-020 Y SHALL be compared with expected Y only in the cycle where dwell counter = DWELL-1.
REQ-021 On a mismatch, on that edge:
- err SHALL be set
- fail_cnt SHALL increment, saturating at 31
- fail_x SHALL capture X only if err was 0 before the edge
REQ-022 On a compare that is not the last code, X SHALL increment by 1 and the dwell counter SHALL reset to 0.
REQ-023 On a compare at the last code, the FSM SHALL enter FINISH with busy=0, and Z/X SHALL hold the last values.
REQ-024 FINISH SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 Sweep duration SHALL be (last code+1)*DWELL cycles of busy=1, from the first busy cycle to the last.
REQ-026 A mismatch at the final compare SHALL be reflected in err/fail_cnt in the same cycle done=1.
REQ-027 err, fail_x and fail_cnt SHALL hold their values in IDLE until the next accepted start.
REQ-028 X SHALL never exceed the last code for the latched mode; no wrap-around occurs within a sweep.

Reset
REQ-029 rst=1 SHALL immediately and asynchronously force:
- state=IDLE
- Z=00, X=0000
- busy=0, done=0
- err=0, fail_x=0, fail_cnt=0
- dwell counter=0
REQ-030 rst asserted mid-sweep SHALL abort the sweep with no done pulse.
REQ-031 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-032 Full-sweep scenario: DWELL=2, correct decoder, start with mode=10 -> busy high 32 cycles; X steps 0..15, each held 2 cycles; done pulses once; err=0, fail_cnt=0.
REQ-033 Small-sweep scenario: mode=00, correct decoder -> X steps 0..3; busy high 8 cycles; Z=00 throughout; done=1 once; err=0.
REQ-034 Fault-injection scenario: mode=01, Y[5] forced 0 -> err=1, fail_x=5, fail_cnt=1 when done=1.
REQ-035 Disabled-mode scenario: mode=11, decoder outputs 16'h0000 -> one step at X=0; busy high 2 cycles; err=0. With Y forced to 16'h0001 -> err=1, fail_x=0.
REQ-036 Mid-sweep reset scenario: rst pulsed at X=6 during a mode=10 sweep -> outputs reset immediately, no done pulse. A start pulse while busy -> ignored, sweep length unchanged.

Source files
------------

// File: rtl/decoder_sweep_ctrl.sv
// Sweep controller for a 2:4 / 3:8 / 4:16 decoder under test: walks every input
// code, holds each one for DWELL cycles and checks the one-hot result in the last cycle.
module decoder_sweep_ctrl #(
    parameter int DWELL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic [1:0]  Z,
    output logic [3:0]  X,
    input  logic [15:0] Y,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  fail_x,
    output logic [4:0]  fail_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     state_r;
    logic [3:0] dwell_r;
    logic       compare_s;
    logic       mismatch_s;
    logic       last_s;

    function automatic logic [3:0] last_code(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd3;
            2'b01:   return 4'd7;
            2'b10:   return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [15:0] expected_y(input logic [1:0] m, input logic [3:0] x);
        if (m == 2'b11) begin
            return 16'h0000;
        end else begin
            return 16'h0001 << x;
        end
    endfunction

    // Z always carries the mode latched at start, so it selects the expected pattern
    assign compare_s  = (state_r == DRIVE) && (dwell_r == DWELL_LAST);
    assign mismatch_s = (Y != expected_y(Z, X));
    assign last_s     = (X == last_code(Z));

    // Sweep FSM with registered decoder drive, status and mismatch bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            dwell_r  <= 4'd0;
            Z        <= 2'b00;
            X        <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            fail_x   <= 4'd0;
            fail_cnt <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r  <= DRIVE;
                        Z        <= mode;
                        X        <= 4'd0;
                        busy     <= 1'b1;
                        dwell_r  <= 4'd0;
                        err      <= 1'b0;
                        fail_x   <= 4'd0;
                        fail_cnt <= 5'd0;
                    end
                end
                DRIVE: begin
                    if (compare_s) begin
                        if (mismatch_s) begin
                            err <= 1'b1;
                            if (fail_cnt != 5'd31) begin
                                fail_cnt <= fail_cnt + 5'd1;
                            end
                            if (!err) begin
                                fail_x <= X;
                            end
                        end
                        if (last_s) begin
                            // Z/X keep the last code so the final compare stays observable
                            state_r <= FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            X       <= X + 4'd1;
                            dwell_r <= 4'd0;
                        end
                    end else begin
                        dwell_r <= dwell_r + 4'd1;
                    end
                end
                FINISH: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_sweep_ctrl.sv
// Bench for decoder_sweep_ctrl: a behavioural decoder with fault masks, a timeline
// model of each sweep checked every cycle, and directed scenarios with literal checks.
module tb_decoder_sweep_ctrl;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  Z;
    logic [3:0]  X;
    logic [15:0] Y;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  fail_x;
    logic [4:0]  fail_cnt;

    logic [15:0] and_mask;
    logic [15:0] or_mask;
    logic [15:0] frc_val;
    logic        frc_en;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    // model of the sweep as a timeline counted from the accepting edge
    logic        m_run;
    logic        m_seen;
    int          m_k;
    logic [1:0]  m_mode;
    logic [15:0] m_am, m_om, m_fv;
    logic        m_fe;

    always #5 clk = ~clk;

    decoder_sweep_ctrl #(.DWELL(D)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .Z(Z), .X(X), .Y(Y), .busy(busy), .done(done),
        .err(err), .fail_x(fail_x), .fail_cnt(fail_cnt)
    );

    function automatic logic [15:0] ideal_y(input logic [1:0] m, input int c);
        logic [15:0] one;
        one = 16'h0001;
        return (m == 2'b11) ? 16'h0000 : (one << c);
    endfunction

    function automatic logic [15:0] dec_y(input logic [1:0] m, input int c,
                                          input logic [15:0] am, input logic [15:0] om,
                                          input logic fe, input logic [15:0] fv);
        if (fe) return fv;
        return (ideal_y(m, c) & ~am) | om;
    endfunction

    function automatic int codes(input logic [1:0] m);
        case (m)
            2'b00:   return 4;
            2'b01:   return 8;
            2'b10:   return 16;
            default: return 1;
        endcase
    endfunction

    assign Y = dec_y(Z, int'(X), and_mask, or_mask, frc_en, frc_val);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // timeline advance: accept start only when idle, stop one cycle after the last busy cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_seen <= 1'b0;
            m_k    <= 0;
            m_mode <= 2'b00;
        end else if (!m_run) begin
            if (start) begin
                m_run  <= 1'b1;
                m_seen <= 1'b1;
                m_k    <= 1;
                m_mode <= mode;
                m_am   <= and_mask;
                m_om   <= or_mask;
                m_fe   <= frc_en;
                m_fv   <= frc_val;
            end
        end else if (m_k == codes(m_mode) * D + 1) begin
            m_run <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // per-cycle comparison of every output against the timeline model
    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (!m_seen) begin
                check("cyc_Z", 32'(Z), 32'd0);
                check("cyc_X", 32'(X), 32'd0);
                check("cyc_busy", 32'(busy), 32'd0);
                check("cyc_done", 32'(done), 32'd0);
                check("cyc_err", 32'(err), 32'd0);
                check("cyc_fail_x", 32'(fail_x), 32'd0);
                check("cyc_fail_cnt", 32'(fail_cnt), 32'd0);
            end else begin
                int n, c, xe, cnt, fx;
                logic be, de, ee;
                n   = codes(m_mode);
                c   = (m_k - 1) / D;
                xe  = (c > n - 1) ? n - 1 : c;
                be  = m_run && (m_k <= n * D);
                de  = m_run && (m_k == n * D + 1);
                ee  = 1'b0;
                cnt = 0;
                fx  = 0;
                for (int i = 0; i < c; i++) begin
                    if (dec_y(m_mode, i, m_am, m_om, m_fe, m_fv) != ideal_y(m_mode, i)) begin
                        if (!ee) fx = i;
                        ee = 1'b1;
                        cnt++;
                    end
                end
                if (cnt > 31) cnt = 31;
                check("cyc_Z", 32'(Z), 32'(m_mode));
                check("cyc_X", 32'(X), 32'(xe));
                check("cyc_busy", 32'(busy), 32'(be));
                check("cyc_done", 32'(done), 32'(de));
                check("cyc_err", 32'(err), 32'(ee));
                check("cyc_fail_x", 32'(fail_x), 32'(fx));
                check("cyc_fail_cnt", 32'(fail_cnt), 32'(cnt));
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        if (done_cnt == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected one within 200 cycles");
        end
        repeat (2) tick();
    endtask

    task automatic do_sweep(input logic [1:0] md);
        busy_cnt = 0;
        done_cnt = 0;
        mode  = md;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'b00;
        and_mask = 16'h0000; or_mask = 16'h0000; frc_en = 1'b0; frc_val = 16'h0000;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_X", 32'(X), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // full 4:16 sweep with a good decoder
        do_sweep(2'b10);
        check("full_busy_len", busy_cnt, 32);
        check("full_done_cnt", done_cnt, 1);
        check("full_err", 32'(err), 32'd0);
        check("full_fail_cnt", 32'(fail_cnt), 32'd0);
        check("full_X_last", 32'(X), 32'd15);

        // small 2:4 sweep
        do_sweep(2'b00);
        check("small_busy_len", busy_cnt, 8);
        check("small_done_cnt", done_cnt, 1);
        check("small_Z", 32'(Z), 32'd0);
        check("small_X_last", 32'(X), 32'd3);

        // Y[5] stuck low on a 3:8 sweep
        and_mask = 16'h0020;
        do_sweep(2'b01);
        check("fault_busy_len", busy_cnt, 16);
        check("fault_err", 32'(err), 32'd1);
        check("fault_fail_x", 32'(fail_x), 32'd5);
        check("fault_fail_cnt", 32'(fail_cnt), 32'd1);

        // two faults: first one captured, count covers both
        and_mask = 16'h0480;
        do_sweep(2'b10);
        check("two_fail_x", 32'(fail_x), 32'd7);
        check("two_fail_cnt", 32'(fail_cnt), 32'd2);
        and_mask = 16'h0000;
        repeat (3) tick();
        check("hold_err", 32'(err), 32'd1);
        check("hold_fail_cnt", 32'(fail_cnt), 32'd2);

        // disabled mode, decoder silent
        do_sweep(2'b11);
        check("dis_busy_len", busy_cnt, 2);
        check("dis_err", 32'(err), 32'd0);
        check("dis_Z", 32'(Z), 32'd3);

        // disabled mode, decoder drives bit 0
        frc_en = 1'b1; frc_val = 16'h0001;
        do_sweep(2'b11);
        check("dis_frc_err", 32'(err), 32'd1);
        check("dis_frc_fail_x", 32'(fail_x), 32'd0);
        check("dis_frc_fail_cnt", 32'(fail_cnt), 32'd1);
        frc_en = 1'b0; frc_val = 16'h0000;

        // start while busy is ignored, mode not relatched
        busy_cnt = 0; done_cnt = 0;
        mode = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        check("restart_busy_len", busy_cnt, 32);
        check("restart_done_cnt", done_cnt, 1);
        check("restart_Z", 32'(Z), 32'd2);

        // asynchronous reset in the middle of a sweep
        and_mask = 16'h0004;
        busy_cnt = 0; done_cnt = 0;
        mode = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 100 && X != 4'd6; n++) tick();
        check("mid_reach_x6", 32'(X), 32'd6);
        check("mid_err_before", 32'(err), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_X", 32'(X), 32'd0);
        check("mid_rst_Z", 32'(Z), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_fail_cnt", 32'(fail_cnt), 32'd0);
        tick();
        rst = 1'b0;
        check("mid_no_done", done_cnt, 0);
        and_mask = 16'h0000;

        // first edge after reset release with start=1 is accepted
        do_sweep(2'b00);
        check("post_rst_busy_len", busy_cnt, 8);
        check("post_rst_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
